// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath types, byte accessor and InvSubBytes FSM state
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef logic [7:0] aes_byte_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_sb_state_e;
  function automatic aes_byte_t get_byte(aes_state_t state, logic [3:0] idx);
    return state[8*(15-int'(idx)) +: 8];
  endfunction
endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if: input/output valid-ready streams plus abort/busy of the InvSubBytes engine
// slave (engine): in_valid/in_data/out_ready/abort in; in_ready/out_valid/out_data/busy out
// master (source/sink): mirror image of slave
interface inv_sub_bytes_seq_if;
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  aes_state_t in_data;
  logic out_valid;
  logic out_ready;
  aes_state_t out_data;
  logic abort;
  logic busy;
  modport slave (input in_valid, in_data, out_ready, abort, output in_ready, out_valid, out_data, busy);
  modport master (output in_valid, in_data, out_ready, abort, input in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/s_box_inv.sv
// s_box_inv: combinational AES inverse S-box
// i_byte: byte to substitute; o_byte: inverse S-box of i_byte
module s_box_inv (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [0:255][7:0] TBL = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  assign o_byte = TBL[i_byte];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: multi-cycle InvSubBytes, LANES bytes per cycle through shared inverse S-boxes
// clk/rst_n: clock and async active-low reset; bus (slave): in/out valid-ready streams, abort, busy
module inv_sub_bytes_seq import aes_pkg::*; #(
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst_n,
  inv_sub_bytes_seq_if.slave bus
);
  localparam int NBEATS = 16 / LANES;
  localparam int CW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  if (LANES < 1 || LANES > 16 || 16 % LANES != 0) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES=%0d must divide 16", LANES);
  end
  inv_sb_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  aes_state_t r_data, w_sub;
  aes_byte_t w_in [LANES];
  aes_byte_t w_out [LANES];
  logic w_last, w_ld, w_step;
  assign w_last = r_cnt == CW'(NBEATS - 1);
  assign w_ld = r_state == IDLE && bus.in_valid && !bus.abort;
  assign w_step = r_state == BUSY && !bus.abort;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_in[l] = get_byte(r_data, 4'(int'(r_cnt) * LANES + l));
    s_box_inv u_sbox (.i_byte(w_in[l]), .o_byte(w_out[l]));
  end
  // only the window selected by the beat counter takes the S-box results
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign w_sub[8*(15-i) +: 8] = r_cnt == CW'(i / LANES) ? w_out[i % LANES] : get_byte(r_data, 4'(i));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_step && !w_last ? r_cnt + 1'b1 : '0;
      r_data <= w_ld ? bus.in_data : w_step ? w_sub : r_data;
    end
  always_comb
    w_next = bus.abort ? IDLE :
             r_state == IDLE ? (bus.in_valid ? BUSY : IDLE) :
             r_state == BUSY ? (w_last ? DONE : BUSY) :
             (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.busy = r_state != IDLE;
  end
  assign bus.out_data = r_data;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: directed scoreboard bench for inv_sub_bytes_seq at LANES=4, 1 and 16
module tb_inv_sub_bytes_seq;
  logic clk = 0;
  logic rst_n = 1;
  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] q4 [$];
  logic [127:0] q1 [$];
  logic [127:0] q16 [$];
  localparam logic [127:0] RAMP = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RAMP_EXP = 128'h52096ad53036a538bf40a39e81f3d7fb;
  always #5 clk = ~clk;
  inv_sub_bytes_seq_if b4 ();
  inv_sub_bytes_seq_if b1 ();
  inv_sub_bytes_seq_if b16 ();
  inv_sub_bytes_seq #(.LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  inv_sub_bytes_seq #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  inv_sub_bytes_seq #(.LANES(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction
  // inverse affine transform followed by GF(2^8) inversion (y^254, which maps 0 to 0)
  function automatic logic [7:0] isb(logic [7:0] x);
    logic [7:0] y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, y);
    return r;
  endfunction
  function automatic logic [127:0] model(logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isb(d[8*i +: 8]);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chki(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) chki("out4_unexpected", int'(b4.out_valid), 0);
      else chk("out4_data", b4.out_data, q4.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) chki("out1_unexpected", int'(b1.out_valid), 0);
      else chk("out1_data", b1.out_data, q1.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) chki("out16_unexpected", int'(b16.out_valid), 0);
      else chk("out16_data", b16.out_data, q16.pop_front());
    end
  task automatic send(input logic [127:0] d, input bit track);
    b4.in_data = d;
    b4.in_valid = 1;
    if (track) q4.push_back(model(d));
    @(posedge clk);
    #1 b4.in_valid = 0;
  endtask
  task automatic wait_ov(output int k);
    k = 0;
    while (!b4.out_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
  endtask
  initial begin
    int k;
    bit was;
    logic [127:0] d, e;
    b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 1; b4.abort = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 1; b1.abort = 0;
    b16.in_valid = 0; b16.in_data = '0; b16.out_ready = 1; b16.abort = 0;
    #2 rst_n = 0;
    #10;
    chki("rst_in_ready", int'(b4.in_ready), 1);
    chki("rst_out_valid", int'(b4.out_valid), 0);
    chki("rst_busy", int'(b4.busy), 0);
    chk("rst_out_data", b4.out_data, '0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    chki("idle_in_ready", int'(b4.in_ready), 1);
    send(RAMP, 1);
    wait_ov(k);
    chki("ramp_latency", k, 4);
    chk("ramp_const", b4.out_data, RAMP_EXP);
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      d = {16{p == 0 ? 8'h63 : p == 1 ? 8'h00 : 8'hff}};
      e = {16{p == 0 ? 8'h00 : p == 1 ? 8'h52 : 8'h7d}};
      send(d, 1);
      wait_ov(k);
      chki("pat_latency", k, 4);
      chk("pat_const", b4.out_data, e);
      @(posedge clk);
      #1;
    end
    b4.out_ready = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = model(d);
    send(d, 1);
    wait_ov(k);
    chki("bp_latency", k, 4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data", b4.out_data, e);
      chki("bp_out_valid", int'(b4.out_valid), 1);
      chki("bp_in_ready", int'(b4.in_ready), 0);
      chki("bp_busy", int'(b4.busy), 1);
      @(posedge clk);
      #1;
    end
    b4.out_ready = 1;
    @(posedge clk);
    #1;
    chki("bp_release_valid", int'(b4.out_valid), 0);
    chki("bp_release_ready", int'(b4.in_ready), 1);
    b4.in_data = {$urandom, $urandom, $urandom, $urandom};
    b4.in_valid = 1;
    q4.push_back(model(b4.in_data));
    @(posedge clk);
    #1 b4.in_data = {$urandom, $urandom, $urandom, $urandom};
    q4.push_back(model(b4.in_data));
    k = 0;
    do begin
      was = b4.in_ready;
      @(posedge clk);
      #1 k++;
    end while (!was && k < 20);
    b4.in_valid = 0;
    chki("b2b_period", k, 6);
    wait_ov(k);
    chki("b2b_latency", k, 4);
    @(posedge clk);
    #1;
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    @(posedge clk);
    #1 b4.abort = 1;
    @(posedge clk);
    #1 b4.abort = 0;
    chki("abort_in_ready", int'(b4.in_ready), 1);
    chki("abort_busy", int'(b4.busy), 0);
    for (int i = 0; i < 6; i++) begin
      chki("abort_no_out", int'(b4.out_valid), 0);
      @(posedge clk);
      #1;
    end
    send({16{8'h63}}, 1);
    wait_ov(k);
    chk("abort_next_const", b4.out_data, '0);
    @(posedge clk);
    #1 b4.abort = 1;
    b4.in_valid = 1;
    b4.in_data = RAMP;
    @(posedge clk);
    #1 b4.abort = 0;
    b4.in_valid = 0;
    chki("abort_idle_in_ready", int'(b4.in_ready), 1);
    chki("abort_idle_busy", int'(b4.busy), 0);
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chki("arst_out_valid", int'(b4.out_valid), 0);
    chki("arst_busy", int'(b4.busy), 0);
    chki("arst_in_ready", int'(b4.in_ready), 1);
    chk("arst_out_data", b4.out_data, '0);
    #2 rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chki("arst_no_out", int'(b4.out_valid), 0);
    end
    b1.in_data = RAMP;
    b1.in_valid = 1;
    q1.push_back(model(RAMP));
    @(posedge clk);
    #1 b1.in_valid = 0;
    k = 0;
    while (!b1.out_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chki("l1_latency", k, 16);
    chk("l1_const", b1.out_data, RAMP_EXP);
    b16.in_data = RAMP;
    b16.in_valid = 1;
    q16.push_back(model(RAMP));
    @(posedge clk);
    #1 b16.in_valid = 0;
    k = 0;
    while (!b16.out_valid && k < 40) begin
      @(posedge clk);
      #1 k++;
    end
    chki("l16_latency", k, 1);
    chk("l16_const", b16.out_data, RAMP_EXP);
    repeat (3) @(posedge clk);
    #1;
    chki("q4_drained", q4.size(), 0);
    chki("q1_drained", q1.size(), 0);
    chki("q16_drained", q16.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Multi-cycle InvSubBytes engine for the AES decryption round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES shared inverse S-box instances. It returns the substituted state over a second valid/ready handshake. It sits between the InvShiftRows and AddRoundKey stages and trades latency for S-box area.

## Interface
- LANES, 4, inverse S-box instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- NBEATS, 16/LANES, derived localparam (not overridable); number of substitution cycles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous abort; drops any block in flight.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  128  state to substitute; byte 0 = bits [127:120], byte 15 = bits [7:0].
- out_valid  output  1  out_data holds a finished block.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  substituted state, same byte order as in_data.
- busy  output  1  high while in BUSY or DONE.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid, capture in_data into the state register, clear the beat counter and go to BUSY.
- **BUSY**
  - Each cycle, bytes beat*LANES to beat*LANES+LANES-1 of the state register are replaced in place by inv_sbox(byte); the beat counter then increments.
  - Bytes outside the current window are unchanged.
  - After the beat with counter = NBEATS-1, go to DONE.
- **DONE**
  - out_valid=1 and out_data = state register, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- in_ready is high only in IDLE. No input is accepted in BUSY or DONE, even if out_ready is high that cycle.
- abort has priority over every transition: next state is IDLE, counter is cleared, out_valid drops, and the state register is not cleared.
- abort in IDLE together with in_valid: the block is not accepted.
- Beat counter width is $clog2(NBEATS), minimum 1 bit. It never wraps; exit happens at NBEATS-1.
- For LANES=16: one BUSY cycle.
- The S-box is purely combinational. The byte mux feeding it is selected by the beat counter.

## Timing
- Reset values:
  - state IDLE, counter 0, state register 0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
- in_ready, out_valid and busy are decoded from registered FSM state only; they have no combinational path from inputs.
- Latency: block accepted at edge T gives out_valid high from edge T+NBEATS; LANES=4 → 4 cycles.
- Minimum block period, with out_ready held high: NBEATS+2 cycles (accept cycle, NBEATS BUSY cycles, one DONE cycle); LANES=4 → 6.
- Backpressure: DONE is held indefinitely while out_ready=0. out_data must not change during the hold.
- rst_n asserted mid-operation: immediate return to reset values. The in-flight block is lost and no out_valid is produced.
- out_data is directly the state register. It is meaningful only while out_valid=1.

## Structure
- aes_pkg (shared package) holds:
  - typedef aes_state_t = logic [127:0];
  - typedef aes_byte_t = logic [7:0];
  - function get_byte(state, idx) using the byte order above;
  - enum inv_sb_state_e {IDLE, BUSY, DONE}.
- Sub-module: the existing s_box_inv, instantiated LANES times in a generate loop. There is no other sub-module.
- Elaboration check: $error if 16 % LANES != 0 or LANES > 16.

## Test plan
- Reset then ramp: in_data=0x000102030405060708090a0b0c0d0e0f with out_ready=1 → out_valid exactly 4 cycles after accept, out_data=0x52096ad53036a538bf40a39e81f3d7fb.
- Fixed patterns: in_data all-0x63 → all-0x00; in_data all-0x00 → all-0x52; in_data all-0xff → all-0x7d.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable; in_ready=0 and busy=1 throughout; handshake completes on the first out_ready=1 cycle.
- Back-to-back: in_valid held high with two blocks and out_ready=1 → second block accepted exactly 6 cycles after the first.
- Abort: assert abort on the 2nd BUSY cycle → next cycle IDLE with in_ready=1; no out_valid for that block; a following all-0x63 block gives all-0x00.
- Async reset: drop rst_n mid-BUSY, away from a clock edge → out_valid=0, busy=0, in_ready=1 immediately. Repeat the ramp test with LANES=1 (latency 16) and LANES=16 (latency 1).
